matrix_tile_scheduler: RTL and testbench
========================================

# matrix_tile_scheduler

Sequencer for the matrix multiply datapath: walks the output matrix tile by tile, where a tile is one row times CORE_COUNT adjacent columns. For each tile it clears the MAC cores, streams K operand address pairs, then issues one write-back strobe with a per-core valid mask. It sits between the bus-side control register (start and sizes) and the core array plus result-matrix write port, and reports busy, done and error status back to the register file.

## Interface
- CORE_COUNT, 6, number of parallel MAC cores; each tile covers this many output columns.
- SIZE_ROW_MAX, 8, maximum first-matrix rows M and second-matrix columns N.
- SIZE_COLUMN_MAX, 4, maximum inner dimension K.
- ADR_W, 5, width of every index output.
- CLOCK_25  in  1  single clock; all state on rising edge.
- rst  in  1  reset, asynchronous, active-high; forces IDLE and zeroes every output.
- start  in  1  level from the control register; its rising edge launches a job.
- m_size  in  8  M, rows of the first matrix.
- k_size  in  8  K, inner dimension.
- n_size  in  8  N, columns of the second matrix.
- busy  out  1  high from the first CLEAR cycle through the last WRITE cycle.
- done  out  1  job complete; sticky until the next launch.
- err  out  1  size check failed at launch; sticky until the next launch.
- acc_clr  out  1  one-cycle clear pulse to all cores.
- acc_en  out  1  cores accumulate a*b this cycle.
- row_adr  out  ADR_W  current output row r.
- k_adr  out  ADR_W  current inner index k.
- col_base  out  ADR_W  first output column c of the current tile.
- wb_en  out  1  write-back strobe.
- wb_row  out  ADR_W  write-back row.
- wb_col  out  ADR_W  write-back base column.
- wb_mask  out  CORE_COUNT  bit i set means core i writes to column wb_col+i.

## Operation
- States: IDLE, CLEAR, ACCUM, WRITE, DONE.
- Launch:
  - A start rising edge (start high, registered start_q low) in IDLE or DONE launches a job. Start edges in any other state are ignored.
  - The sizes are latched at launch.
  - At launch, done and err clear. r, k and c are zeroed.
- Size checks at launch:
  - If any size is 0, go directly to DONE. No wb_en is issued and err stays 0.
  - If M > SIZE_ROW_MAX, N > SIZE_ROW_MAX, or K > SIZE_COLUMN_MAX, go to DONE with err=1 and issue no write-back.
- CLEAR: acc_clr=1 for one cycle, then ACCUM.
- ACCUM:
  - acc_en=1 and k_adr=k, for k = 0..K-1.
  - After k=K-1, go to WRITE.
- WRITE:
  - wb_en=1, wb_row=r, wb_col=c.
  - wb_mask[i] = (c+i < N).
  - Next tile:
    - If c+CORE_COUNT < N, then c += CORE_COUNT and go to CLEAR.
    - Otherwise c=0 and r++. If the new r equals M, go to DONE; otherwise go to CLEAR.
- DONE: done=1 and busy=0; wait for a start rising edge.
- Arithmetic:
  - Compare c+i and c+CORE_COUNT at 9 bits so there is no wrap-around.
  - Index outputs are the low ADR_W bits of internal counters. The size checks guarantee they fit.
- rst mid-job: immediate return to IDLE, all outputs 0, no further wb_en. If start is still high after rst, it does not launch a job, because start_q resets to 1.

## Timing
- Reset values: every output 0. start_q resets to 1.
- Launch latency: one cycle. The edge is sampled at cycle t, and acc_clr is high in cycle t+1.
- Cycles per tile: K+2 (1 CLEAR, K ACCUM, 1 WRITE).
- Job length: M * ceil(N/CORE_COUNT) * (K+2) cycles of busy. done rises the cycle after the last WRITE.
- Address stability:
  - row_adr, k_adr and col_base are registered and valid in the same cycle as acc_en.
  - The cores register their product, so the WRITE cycle follows the last ACCUM cycle directly.
  - wb_row, wb_col and wb_mask are valid only while wb_en=1 and are 0 otherwise.
- Zero-size or error launch: done (and err, if set) high one cycle after the edge. busy never rises.

## Configuration
- MATRIX_SCHED_PERF_EN defined:
  - Adds output perf_cycles [31:0], which counts cycles with busy=1.
  - The counter clears at launch and holds its value in DONE and IDLE.
  - rst zeroes it.
- MATRIX_SCHED_PERF_EN not defined: the port and counter are absent. All other behaviour is identical.

## Test plan
- M=2, K=3, N=4, CORE_COUNT=6:
  - Required response: 2 tiles, 10 busy cycles, wb_en pulses at (row 0, col 0) and (row 1, col 0), each with wb_mask=6'b001111, then done=1.
- M=1, K=2, N=8, CORE_COUNT=6:
  - Required response: wb_en at col 0 with mask 6'b111111, then at col 6 with mask 6'b000011.
  - k_adr sequence is 0,1 per tile. Job is 8 cycles.
- k_size=0: done=1 one cycle after the start edge, busy never rises, no wb_en, err=0.
- n_size=9 with SIZE_ROW_MAX=8: err=1 and done=1 one cycle after the edge, no acc_clr or wb_en. A relaunch with valid sizes clears err.
- Hold start high across a job, and pulse start again mid-job:
  - The mid-job edge is ignored.
  - Holding start high does not relaunch. After start falls, a new rising edge starts a second job.
- Assert rst during ACCUM of the 2nd tile of the 2x3x4 job: all outputs 0 immediately, no wb_en afterward, no relaunch while start remains high. With MATRIX_SCHED_PERF_EN defined, perf_cycles=10 after an uninterrupted 2x3x4 job.

Source files
------------

// File: rtl/matrix_tile_scheduler.sv
// matrix_tile_scheduler: walks the output matrix one tile at a time.
// A tile is one row by CORE_COUNT adjacent columns. Each tile is handled as:
// clear the MAC cores, stream K operand addresses, then one masked write-back.
// Optional feature macro: MATRIX_SCHED_PERF_EN adds the perf_cycles busy-cycle counter.
module matrix_tile_scheduler #(
    parameter int unsigned CORE_COUNT      = 6,
    parameter int unsigned SIZE_ROW_MAX    = 8,
    parameter int unsigned SIZE_COLUMN_MAX = 4,
    parameter int unsigned ADR_W           = 5
) (
    input  logic                  CLOCK_25,
    input  logic                  rst,
    input  logic                  start,
    input  logic [7:0]            m_size,
    input  logic [7:0]            k_size,
    input  logic [7:0]            n_size,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic                  acc_clr,
    output logic                  acc_en,
    output logic [ADR_W-1:0]      row_adr,
    output logic [ADR_W-1:0]      k_adr,
    output logic [ADR_W-1:0]      col_base,
    output logic                  wb_en,
    output logic [ADR_W-1:0]      wb_row,
    output logic [ADR_W-1:0]      wb_col,
    output logic [CORE_COUNT-1:0] wb_mask
`ifdef MATRIX_SCHED_PERF_EN
    ,
    output logic [31:0]           perf_cycles
`endif
);

    localparam int unsigned SIZE_W = 8;
    localparam int unsigned CMP_W  = 9;
    localparam logic [SIZE_W-1:0] ROW_MAX  = SIZE_W'(SIZE_ROW_MAX);
    localparam logic [SIZE_W-1:0] COL_MAX  = SIZE_W'(SIZE_COLUMN_MAX);
    localparam logic [SIZE_W-1:0] CORE_STEP = SIZE_W'(CORE_COUNT);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_ACCUM = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t            r_state, w_state_nx;
    logic              r_start_q;
    logic [SIZE_W-1:0] r_m, r_k_sz, r_n;
    logic [SIZE_W-1:0] r_row, r_k, r_col;
    logic              r_err;
    logic [SIZE_W-1:0] w_m_nx, w_k_sz_nx, w_n_nx;
    logic [SIZE_W-1:0] w_row_nx, w_k_nx, w_col_nx;
    logic              w_err_nx;
    logic              w_launch;
    logic              w_size_zero, w_size_over;

    logic                  w_busy_nx, w_done_nx, w_clr_nx, w_en_nx, w_wb_nx;
    logic [ADR_W-1:0]      w_wb_row_nx, w_wb_col_nx;
    logic [CORE_COUNT-1:0] w_wb_mask_nx;

    assign w_launch    = start && !r_start_q && (r_state == S_IDLE || r_state == S_DONE);
    assign w_size_zero = (m_size == '0) || (k_size == '0) || (n_size == '0);
    assign w_size_over = (m_size > ROW_MAX) || (n_size > ROW_MAX) || (k_size > COL_MAX);

    // State, counters and latched sizes
    always_ff @(posedge CLOCK_25 or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_start_q <= 1'b1;
            r_m       <= '0;
            r_k_sz    <= '0;
            r_n       <= '0;
            r_row     <= '0;
            r_k       <= '0;
            r_col     <= '0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            r_start_q <= start;
            r_m       <= w_m_nx;
            r_k_sz    <= w_k_sz_nx;
            r_n       <= w_n_nx;
            r_row     <= w_row_nx;
            r_k       <= w_k_nx;
            r_col     <= w_col_nx;
            r_err     <= w_err_nx;
        end
    end

    // Next state: launch checks and tile walk
    always_comb begin
        w_state_nx = r_state;
        w_m_nx     = r_m;
        w_k_sz_nx  = r_k_sz;
        w_n_nx     = r_n;
        w_row_nx   = r_row;
        w_k_nx     = r_k;
        w_col_nx   = r_col;
        w_err_nx   = r_err;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (w_launch) begin
                    w_m_nx    = m_size;
                    w_k_sz_nx = k_size;
                    w_n_nx    = n_size;
                    w_row_nx  = '0;
                    w_k_nx    = '0;
                    w_col_nx  = '0;
                    w_err_nx  = 1'b0;
                    if (w_size_zero) begin
                        w_state_nx = S_DONE;
                    end else if (w_size_over) begin
                        w_state_nx = S_DONE;
                        w_err_nx   = 1'b1;
                    end else begin
                        w_state_nx = S_CLEAR;
                    end
                end
            end
            S_CLEAR: begin
                w_state_nx = S_ACCUM;
                w_k_nx     = '0;
            end
            S_ACCUM: begin
                if (r_k == r_k_sz - 8'd1) w_state_nx = S_WRITE;
                else                      w_k_nx     = r_k + 8'd1;
            end
            S_WRITE: begin
                if (CMP_W'(r_col) + CMP_W'(CORE_COUNT) < CMP_W'(r_n)) begin
                    w_col_nx   = r_col + CORE_STEP;
                    w_state_nx = S_CLEAR;
                end else begin
                    w_col_nx   = '0;
                    w_row_nx   = r_row + 8'd1;
                    w_state_nx = (r_row + 8'd1 == r_m) ? S_DONE : S_CLEAR;
                end
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    // Output decode from the upcoming state so every output is a flop
    always_comb begin
        w_busy_nx    = (w_state_nx == S_CLEAR) || (w_state_nx == S_ACCUM) || (w_state_nx == S_WRITE);
        w_done_nx    = (w_state_nx == S_DONE);
        w_clr_nx     = (w_state_nx == S_CLEAR);
        w_en_nx      = (w_state_nx == S_ACCUM);
        w_wb_nx      = (w_state_nx == S_WRITE);
        w_wb_row_nx  = '0;
        w_wb_col_nx  = '0;
        w_wb_mask_nx = '0;
        if (w_state_nx == S_WRITE) begin
            w_wb_row_nx = ADR_W'(w_row_nx);
            w_wb_col_nx = ADR_W'(w_col_nx);
            for (int i = 0; i < int'(CORE_COUNT); i++) begin
                w_wb_mask_nx[i] = (CMP_W'(w_col_nx) + CMP_W'(i)) < CMP_W'(w_n_nx);
            end
        end
    end

    // Output registers
    always_ff @(posedge CLOCK_25 or posedge rst) begin
        if (rst) begin
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            acc_clr  <= 1'b0;
            acc_en   <= 1'b0;
            row_adr  <= '0;
            k_adr    <= '0;
            col_base <= '0;
            wb_en    <= 1'b0;
            wb_row   <= '0;
            wb_col   <= '0;
            wb_mask  <= '0;
        end else begin
            busy     <= w_busy_nx;
            done     <= w_done_nx;
            err      <= w_err_nx;
            acc_clr  <= w_clr_nx;
            acc_en   <= w_en_nx;
            row_adr  <= ADR_W'(w_row_nx);
            k_adr    <= ADR_W'(w_k_nx);
            col_base <= ADR_W'(w_col_nx);
            wb_en    <= w_wb_nx;
            wb_row   <= w_wb_row_nx;
            wb_col   <= w_wb_col_nx;
            wb_mask  <= w_wb_mask_nx;
        end
    end

`ifdef MATRIX_SCHED_PERF_EN
    logic [31:0] r_perf;

    // Busy-cycle counter, cleared at each launch
    always_ff @(posedge CLOCK_25 or posedge rst) begin
        if (rst)           r_perf <= '0;
        else if (w_launch) r_perf <= '0;
        else if (busy)     r_perf <= r_perf + 32'd1;
    end

    assign perf_cycles = r_perf;
`endif

endmodule

// File: tb/tb_matrix_tile_scheduler.sv
// Bench for matrix_tile_scheduler: directed cases plus randomized jobs compared
// against a per-cycle trace built from nested row/tile/k loops.
module tb_matrix_tile_scheduler;

    localparam int CC = 6;
    localparam int AW = 5;

    logic          CLOCK_25 = 1'b0;
    logic          rst;
    logic          start;
    logic [7:0]    m_size, k_size, n_size;
    logic          busy, done, err, acc_clr, acc_en, wb_en;
    logic [AW-1:0] row_adr, k_adr, col_base, wb_row, wb_col;
    logic [CC-1:0] wb_mask;
`ifdef MATRIX_SCHED_PERF_EN
    logic [31:0]   perf_cycles;
`endif

    int n_checks = 0;
    int n_errs   = 0;

    matrix_tile_scheduler dut (
        .CLOCK_25 (CLOCK_25),
        .rst      (rst),
        .start    (start),
        .m_size   (m_size),
        .k_size   (k_size),
        .n_size   (n_size),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .acc_clr  (acc_clr),
        .acc_en   (acc_en),
        .row_adr  (row_adr),
        .k_adr    (k_adr),
        .col_base (col_base),
        .wb_en    (wb_en),
        .wb_row   (wb_row),
        .wb_col   (wb_col),
        .wb_mask  (wb_mask)
`ifdef MATRIX_SCHED_PERF_EN
        ,
        .perf_cycles (perf_cycles)
`endif
    );

    always #20 CLOCK_25 = ~CLOCK_25;

    task automatic check_eq(input string tag, input logic [47:0] got, input logic [47:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected observation vector
    function automatic logic [47:0] ev(input bit b, input bit d, input bit e, input bit cl,
                                       input bit en, input bit wb, input logic [4:0] k,
                                       input logic [4:0] r, input logic [4:0] c,
                                       input logic [4:0] wr, input logic [4:0] wc,
                                       input logic [5:0] mk);
        return 48'({b, d, e, cl, en, wb, k, r, c, wr, wc, mk});
    endfunction

    // Observed outputs; operand addresses only meaningful while acc_en is high
    function automatic logic [47:0] pack_obs();
        return ev(busy, done, err, acc_clr, acc_en, wb_en,
                  acc_en ? k_adr : 5'd0, acc_en ? row_adr : 5'd0, acc_en ? col_base : 5'd0,
                  wb_row, wb_col, wb_mask);
    endfunction

    function automatic logic [47:0] pack_raw();
        return ev(busy, done, err, acc_clr, acc_en, wb_en, k_adr, row_adr, col_base,
                  wb_row, wb_col, wb_mask);
    endfunction

    // Launch a job and compare every cycle against the expected trace
    task automatic run_job(input int m, input int k, input int n, input bit hold,
                           input int pulse_at, input int rst_at);
        logic [47:0] q[$];
        logic [5:0]  mk;
        bit          zero, ov;
        start = 1'b0;
        @(negedge CLOCK_25);
        start  = 1'b1;
        m_size = 8'(m);
        k_size = 8'(k);
        n_size = 8'(n);
        @(negedge CLOCK_25);
        if (!hold) start = 1'b0;
        m_size = 8'($urandom);
        k_size = 8'($urandom);
        n_size = 8'($urandom);
        zero = (m == 0) || (k == 0) || (n == 0);
        ov   = !zero && (m > 8 || n > 8 || k > 4);
        if (zero || ov) begin
            for (int i = 0; i < 3; i++) begin
                if (i > 0) @(negedge CLOCK_25);
                check_eq("bad_launch", pack_obs(), ev(0, 1, ov, 0, 0, 0, 0, 0, 0, 0, 0, 0));
            end
            start = 1'b0;
            return;
        end
        for (int r = 0; r < m; r++) begin
            for (int c = 0; c < n; c += CC) begin
                q.push_back(ev(1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
                for (int kk = 0; kk < k; kk++)
                    q.push_back(ev(1, 0, 0, 0, 1, 0, 5'(kk), 5'(r), 5'(c), 0, 0, 0));
                for (int i = 0; i < CC; i++) mk[i] = (c + i < n);
                q.push_back(ev(1, 0, 0, 0, 0, 1, 0, 0, 0, 5'(r), 5'(c), mk));
            end
        end
        for (int i = 0; i < q.size(); i++) begin
            if (i > 0) @(negedge CLOCK_25);
            check_eq("cycle", pack_obs(), q[i]);
            if (i == rst_at) begin
                rst = 1'b1;
                #1;
                check_eq("rst_zero", pack_raw(), 48'd0);
                @(negedge CLOCK_25);
                rst = 1'b0;
                return;
            end
            if (pulse_at >= 0 && (i == pulse_at || i == pulse_at + 1)) start = ~start;
        end
        @(negedge CLOCK_25);
        check_eq("done", pack_obs(), ev(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
`ifdef MATRIX_SCHED_PERF_EN
        check_eq("perf", 48'(perf_cycles), 48'(q.size()));
`endif
        if (hold) begin
            repeat (3) begin
                @(negedge CLOCK_25);
                check_eq("no_relaunch", pack_obs(), ev(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
            end
        end
        start = 1'b0;
    endtask

    initial begin
        rst    = 1'b1;
        start  = 1'b0;
        m_size = '0;
        k_size = '0;
        n_size = '0;
        repeat (3) @(negedge CLOCK_25);
        check_eq("reset", pack_raw(), 48'd0);
        rst = 1'b0;
        @(negedge CLOCK_25);
        check_eq("idle", pack_raw(), 48'd0);

        run_job(2, 3, 4, 0, -1, -1);
        run_job(1, 2, 8, 0, -1, -1);
        run_job(3, 0, 4, 0, -1, -1);
        run_job(2, 3, 9, 0, -1, -1);
        run_job(2, 3, 4, 0, -1, -1);
        run_job(9, 2, 2, 0, -1, -1);
        run_job(1, 5, 2, 0, -1, -1);
        run_job(8, 4, 8, 0, -1, -1);
        run_job(2, 3, 4, 1, 3, -1);
        run_job(1, 2, 8, 0, -1, -1);

        run_job(2, 3, 4, 1, -1, 7);
        repeat (6) begin
            @(negedge CLOCK_25);
            check_eq("post_rst", pack_raw(), 48'd0);
        end
`ifdef MATRIX_SCHED_PERF_EN
        check_eq("perf_rst", 48'(perf_cycles), 48'd0);
`endif
        start = 1'b0;
        run_job(2, 3, 4, 0, -1, -1);

        for (int t = 0; t < 40; t++) begin
            int pa;
            pa = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : -1;
            run_job(int'($urandom_range(0, 9)), int'($urandom_range(0, 5)),
                    int'($urandom_range(0, 10)), 1'($urandom_range(0, 1)), pa, -1);
        end

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
